// File: rtl/alu_pkg.sv
// Shared definitions for the ALU subtract path.
//   ALU_DATA_W    default operand/result width
//   ALU_MAX_REQ   largest number of requesters an arbiter may serve
//   alu_rsp_t     packed response record {dif, ovf, id} at default width
//   rsp_state_e   response-register occupancy (EMPTY / FULL)
package alu_pkg;

  localparam int ALU_DATA_W   = 64;
  localparam int ALU_MAX_REQ  = 8;
  localparam int ALU_MAX_ID_W = $clog2(ALU_MAX_REQ);

  typedef struct packed {
    logic [ALU_DATA_W-1:0]   dif;
    logic                    ovf;
    logic [ALU_MAX_ID_W-1:0] id;
  } alu_rsp_t;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority search.
//   req_valid : per-requester request
//   ptr       : index with highest priority this cycle
//   grant     : one-hot grant (all zero when nothing is requested)
//   grant_idx : binary index of the granted requester
//   grant_any : some requester was granted
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  int             j;
  logic [ID_W-1:0] j_idx;

  // Walk from the lowest priority (ptr + NUM_REQ - 1) down to ptr so the
  // last hit, i.e. the one closest to ptr, wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    j         = 0;
    j_idx     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      j_idx = ID_W'(j);
      if (req_valid[j_idx]) begin
        grant        = '0;
        grant[j_idx] = 1'b1;
        grant_idx    = j_idx;
        grant_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/subtractor.sv
// Combinational DATA_W-bit subtractor.
//   a, b : minuend, subtrahend
//   dif  : a - b modulo 2^DATA_W
//   ovf  : signed two's-complement overflow of a - b
module subtractor #(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] dif,
  output logic              ovf
);

  assign dif = a - b;
  // Overflow only possible when operand signs differ and the result sign
  // disagrees with the minuend.
  assign ovf = (a[DATA_W-1] != b[DATA_W-1]) && (dif[DATA_W-1] != a[DATA_W-1]);

endmodule

// File: rtl/sub_arbiter.sv
// Round-robin arbiter sharing one subtractor among NUM_REQ requesters.
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : per-requester request valid
//   req_a/b    : operands, requester i at [i*DATA_W +: DATA_W]
//   req_ready  : one-hot grant
//   rsp_valid  : response register is FULL
//   rsp_dif    : a - b of the captured operation
//   rsp_ovf    : signed overflow of the captured operation
//   rsp_id     : requester that issued the captured operation
//   rsp_ready  : consumer takes the response this cycle
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high. req_ready may depend combinationally on req_valid and
// rsp_ready; requesters must not make req_valid depend on req_ready and must
// hold valid/operands until granted. rsp_* stay bit-stable while
// rsp_valid & !rsp_ready.
module sub_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W  = alu_pkg::ALU_DATA_W,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_dif,
  output logic                      rsp_ovf,
  output logic [ID_W-1:0]           rsp_id,
  input  logic                      rsp_ready
);

  rsp_state_e        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0] dif_q, dif_d;
  logic              ovf_q, ovf_d;
  logic [ID_W-1:0]   id_q, id_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  logic               accept;
  logic               hs;
  logic [DATA_W-1:0]  op_a, op_b, sub_dif;
  logic               sub_ovf;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // The response slot can take new data if empty or draining this cycle,
  // which gives back-to-back throughput without bubbles.
  assign accept    = (state_q == RSP_EMPTY) || rsp_ready;
  assign req_ready = (accept && !rst) ? grant : '0;
  assign hs        = accept && !rst && grant_any;

  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        op_a = req_a[i*DATA_W +: DATA_W];
        op_b = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  subtractor #(
    .DATA_W (DATA_W)
  ) u_subtractor (
    .a   (op_a),
    .b   (op_b),
    .dif (sub_dif),
    .ovf (sub_ovf)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    dif_d   = dif_q;
    ovf_d   = ovf_q;
    id_d    = id_q;
    if (hs) begin
      state_d = RSP_FULL;
      dif_d   = sub_dif;
      ovf_d   = sub_ovf;
      id_d    = grant_idx;
      ptr_d   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if ((state_q == RSP_FULL) && rsp_ready) begin
      state_d = RSP_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RSP_EMPTY;
      ptr_q   <= '0;
      dif_q   <= '0;
      ovf_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dif_q   <= dif_d;
      ovf_q   <= ovf_d;
      id_q    <= id_d;
    end
  end

  assign rsp_valid = (state_q == RSP_FULL);
  assign rsp_dif   = dif_q;
  assign rsp_ovf   = ovf_q;
  assign rsp_id    = id_q;

endmodule
